// File: rtl/utf_pkg.sv
// Shared constants, FSM state type and byte-ordering helper for the UTF-16
// stream encoder. Optional feature macro: UTF16_BOM_EN adds the BOM states.
package utf_pkg;

    localparam logic [20:0] CP_MAX    = 21'h10FFFF;
    localparam logic [15:0] CP_REPL   = 16'hFFFD;
    localparam logic [15:0] CP_BOM    = 16'hFEFF;
    localparam logic [15:0] SURR_HI   = 16'hD800;
    localparam logic [15:0] SURR_LO   = 16'hDC00;
    localparam logic [20:0] SUPP_BASE = 21'h10000;

    // A = first byte of a unit on the wire, B = second byte
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        U0A   = 3'd1,
        U0B   = 3'd2,
        U1A   = 3'd3,
        U1B   = 3'd4
`ifdef UTF16_BOM_EN
        ,
        BOM_A = 3'd5,
        BOM_B = 3'd6
`endif
    } state_e;

    // Selects the wire byte of a unit: big-endian sends the high byte first,
    // little-endian the low byte first.
    function automatic logic [7:0] pick_byte(input logic [15:0] unit,
                                             input logic        big,
                                             input logic        second);
        pick_byte = (big ^ second) ? unit[15:8] : unit[7:0];
    endfunction

endpackage

// File: rtl/utf16_stream_encoder_if.sv
// Code-point input and byte output handshake bundle of the UTF-16 encoder.
// master = the side feeding code points and sinking bytes, slave = encoder.
interface utf16_stream_encoder_if;

    logic [20:0] cp_in;
    logic        cp_valid;
    logic        cp_ready;
    logic        be;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        invalid;
    logic        busy;

    modport master (
        output cp_in, cp_valid, be, byte_ready,
        input  cp_ready, byte_out, byte_valid, invalid, busy
    );

    modport slave (
        input  cp_in, cp_valid, be, byte_ready,
        output cp_ready, byte_out, byte_valid, invalid, busy
    );

endinterface

// File: rtl/utf16_unit_split.sv
// Combinational code point classifier: produces the surrogate pair halves,
// whether the code point needs two units, and whether it is unencodable.
module utf16_unit_split
    import utf_pkg::*;
(
    input  logic [20:0] cp,
    output logic [15:0] hi,
    output logic [15:0] lo,
    output logic        pair,
    output logic        bad
);

    logic [19:0] v;
    logic        surrogate;
    logic        over;

    // Surrogates share bits [20:11]; the pair halves carry 10 bits each of cp-0x10000
    always_comb begin
        v         = 20'(cp - SUPP_BASE);
        surrogate = (cp[20:11] == {5'd0, SURR_HI[15:11]});
        over      = (cp > CP_MAX);
        bad       = surrogate | over;
        pair      = (cp >= SUPP_BASE) & ~over;
        hi        = SURR_HI | {6'd0, v[19:10]};
        lo        = SURR_LO | {6'd0, v[9:0]};
    end

endmodule

// File: rtl/utf16_stream_encoder.sv
// Serialises accepted 21-bit code points as a UTF-16 byte stream, one byte
// per handshake, big- or little-endian. Optional macro UTF16_BOM_EN prefixes
// the first emitted character after reset with a byte-order mark.
module utf16_stream_encoder
    import utf_pkg::*;
#(
    parameter bit REPLACE_INVALID = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    utf16_stream_encoder_if.slave         bus
);

    state_e      state_q, state_d;
    logic [15:0] unit0_q, unit0_d;
    logic [15:0] unit1_q, unit1_d;
    logic        be_q, be_d;
    logic        pair_q, pair_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        invalid_q, invalid_d;
`ifdef UTF16_BOM_EN
    logic        bom_sent_q, bom_sent_d;
`endif

    logic [15:0] sp_hi, sp_lo;
    logic        sp_pair, sp_bad;
    logic        last_byte, cp_ready, accept, load_drop;
    logic [15:0] load_unit0;

    utf16_unit_split u_split (
        .cp   (bus.cp_in),
        .hi   (sp_hi),
        .lo   (sp_lo),
        .pair (sp_pair),
        .bad  (sp_bad)
    );

    // Accept when idle or while the final byte is leaving, giving no bubble
    always_comb begin
        last_byte  = ((state_q == U0B) && !pair_q) || (state_q == U1B);
        cp_ready   = (state_q == IDLE) || (last_byte && bus.byte_ready);
        accept     = bus.cp_valid && cp_ready;
        load_drop  = sp_bad && !REPLACE_INVALID;
        load_unit0 = sp_bad ? CP_REPL : (sp_pair ? sp_hi : bus.cp_in[15:0]);
    end

    // Next-state: advance one byte per handshake, then overlay a fresh load
    always_comb begin
        state_d      = state_q;
        unit0_d      = unit0_q;
        unit1_d      = unit1_q;
        be_d         = be_q;
        pair_d       = pair_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        invalid_d    = 1'b0;
`ifdef UTF16_BOM_EN
        bom_sent_d   = bom_sent_q;
`endif
        if (byte_valid_q && bus.byte_ready) begin
            case (state_q)
                U0A: begin
                    state_d    = U0B;
                    byte_out_d = pick_byte(unit0_q, be_q, 1'b1);
                end
                U0B: begin
                    if (pair_q) begin
                        state_d    = U1A;
                        byte_out_d = pick_byte(unit1_q, be_q, 1'b0);
                    end else begin
                        state_d      = IDLE;
                        byte_valid_d = 1'b0;
                    end
                end
                U1A: begin
                    state_d    = U1B;
                    byte_out_d = pick_byte(unit1_q, be_q, 1'b1);
                end
`ifdef UTF16_BOM_EN
                BOM_A: begin
                    state_d    = BOM_B;
                    byte_out_d = pick_byte(CP_BOM, be_q, 1'b1);
                end
                BOM_B: begin
                    state_d    = U0A;
                    byte_out_d = pick_byte(unit0_q, be_q, 1'b0);
                end
`endif
                default: begin
                    state_d      = IDLE;
                    byte_valid_d = 1'b0;
                end
            endcase
        end
        if (accept) begin
            invalid_d = sp_bad;
            if (load_drop) begin
                state_d      = IDLE;
                byte_valid_d = 1'b0;
            end else begin
                unit0_d      = load_unit0;
                unit1_d      = sp_lo;
                pair_d       = sp_pair;
                be_d         = bus.be;
                byte_valid_d = 1'b1;
`ifdef UTF16_BOM_EN
                if (!bom_sent_q) begin
                    state_d    = BOM_A;
                    byte_out_d = pick_byte(CP_BOM, bus.be, 1'b0);
                    bom_sent_d = 1'b1;
                end else begin
                    state_d    = U0A;
                    byte_out_d = pick_byte(load_unit0, bus.be, 1'b0);
                end
`else
                state_d    = U0A;
                byte_out_d = pick_byte(load_unit0, bus.be, 1'b0);
`endif
            end
        end
    end

    // State and registered outputs; reset abandons any partly sent character
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            unit0_q      <= 16'h0000;
            unit1_q      <= 16'h0000;
            be_q         <= 1'b0;
            pair_q       <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            invalid_q    <= 1'b0;
`ifdef UTF16_BOM_EN
            bom_sent_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            unit0_q      <= unit0_d;
            unit1_q      <= unit1_d;
            be_q         <= be_d;
            pair_q       <= pair_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            invalid_q    <= invalid_d;
`ifdef UTF16_BOM_EN
            bom_sent_q   <= bom_sent_d;
`endif
        end
    end

    assign bus.cp_ready   = cp_ready;
    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.invalid    = invalid_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_utf16_stream_encoder.sv
// Self-checking bench for utf16_stream_encoder: one instance replaces invalid
// code points, one drops them. Honours UTF16_BOM_EN when defined.
module tb_utf16_stream_encoder;

    typedef struct {
        logic [20:0] cp;
        logic        be;
    } item_t;

`ifdef UTF16_BOM_EN
    localparam bit BOM_ON = 1'b1;
`else
    localparam bit BOM_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sel;
    logic [20:0] cp_in;
    logic        cp_valid;
    logic        be;
    logic        byte_ready;

    logic        obs_ready, obs_valid, obs_invalid, obs_busy;
    logic [7:0]  obs_byte;

    int          n_checks;
    int          n_fail;
    int          inv_seen;
    item_t       cp_list[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_bytes[$];
    bit          pend_inv;
    bit          bom_sent[2];

    utf16_stream_encoder_if if_rep();
    utf16_stream_encoder_if if_drop();

    assign if_rep.cp_in       = cp_in;
    assign if_rep.cp_valid    = cp_valid & ~sel;
    assign if_rep.be          = be;
    assign if_rep.byte_ready  = byte_ready;
    assign if_drop.cp_in      = cp_in;
    assign if_drop.cp_valid   = cp_valid & sel;
    assign if_drop.be         = be;
    assign if_drop.byte_ready = byte_ready;

    utf16_stream_encoder #(.REPLACE_INVALID(1'b1)) dut_rep (
        .clk (clk),
        .rst (rst),
        .bus (if_rep)
    );

    utf16_stream_encoder #(.REPLACE_INVALID(1'b0)) dut_drop (
        .clk (clk),
        .rst (rst),
        .bus (if_drop)
    );

    assign obs_ready   = sel ? if_drop.cp_ready   : if_rep.cp_ready;
    assign obs_valid   = sel ? if_drop.byte_valid : if_rep.byte_valid;
    assign obs_invalid = sel ? if_drop.invalid    : if_rep.invalid;
    assign obs_busy    = sel ? if_drop.busy       : if_rep.busy;
    assign obs_byte    = sel ? if_drop.byte_out   : if_rep.byte_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushCp(input logic [20:0] cp, input logic b);
        item_t it;
        it.cp = cp;
        it.be = b;
        cp_list.push_back(it);
    endtask

    // Reference: turn one accepted code point into its expected wire bytes
    task automatic modelAccept(input item_t it, output bit bad);
        int units[$];
        int v;
        bad = ((it.cp >= 21'h00D800) && (it.cp <= 21'h00DFFF)) || (it.cp > 21'h10FFFF);
        if (bad) begin
            if (!sel) units.push_back(32'hFFFD);
        end else if (it.cp < 21'h010000) begin
            units.push_back(int'(it.cp));
        end else begin
            v = int'(it.cp) - 32'h10000;
            units.push_back(32'hD800 + v / 1024);
            units.push_back(32'hDC00 + v % 1024);
        end
`ifdef UTF16_BOM_EN
        if (units.size() != 0 && !bom_sent[sel]) begin
            units.push_front(32'hFEFF);
            bom_sent[sel] = 1'b1;
        end
`endif
        foreach (units[i]) begin
            if (it.be) begin
                exp_q.push_back(8'(units[i] / 256));
                exp_q.push_back(8'(units[i] % 256));
            end else begin
                exp_q.push_back(8'(units[i] % 256));
                exp_q.push_back(8'(units[i] / 256));
            end
        end
    endtask

    function automatic logic [20:0] randCp();
        logic [20:0] edges [8];
        edges = '{21'h00D7FF, 21'h00E000, 21'h00FFFF, 21'h010000,
                  21'h10FFFF, 21'h110000, 21'h1FFFFF, 21'h00DFFF};
        case ($urandom_range(6))
            0:       randCp = 21'($urandom_range(32'hD7FF));
            1:       randCp = 21'($urandom_range(32'hFFFF, 32'hE000));
            2:       randCp = 21'($urandom_range(32'h10FFFF, 32'h10000));
            3:       randCp = 21'($urandom_range(32'hDFFF, 32'hD800));
            4:       randCp = 21'($urandom_range(32'h1FFFFF, 32'h110000));
            5:       randCp = edges[$urandom_range(7)];
            default: randCp = 21'($urandom_range(127));
        endcase
    endfunction

    // Drives cp_list into the selected DUT cycle by cycle and checks every
    // output against the reference queue. ready_pct < 0 toggles byte_ready.
    task automatic applyStimulus(input int max_cycles, input int ready_pct,
                                 input int valid_pct, input bit expect_drain,
                                 output int used);
        bit exp_valid, exp_ready, bad;
        int cyc;
        cyc = 0;
        while ((cp_list.size() != 0 || exp_q.size() != 0 || pend_inv) && cyc < max_cycles) begin
            cp_valid = (cp_list.size() != 0) && (int'($urandom_range(99)) < valid_pct);
            if (cp_valid) begin
                cp_in = cp_list[0].cp;
                be    = cp_list[0].be;
            end else begin
                cp_in = 21'($urandom);
                be    = 1'($urandom);
            end
            if (ready_pct < 0) byte_ready = ((cyc % 2) == 0);
            else               byte_ready = (int'($urandom_range(99)) < ready_pct);
            @(negedge clk);
            exp_valid = (exp_q.size() != 0);
            exp_ready = !exp_valid || (exp_q.size() == 1 && byte_ready);
            checkOutput("byte_valid", 32'(obs_valid), 32'(exp_valid));
            checkOutput("busy", 32'(obs_busy), 32'(exp_valid));
            checkOutput("invalid", 32'(obs_invalid), 32'(pend_inv));
            checkOutput("cp_ready", 32'(obs_ready), 32'(exp_ready));
            if (exp_valid) checkOutput("byte_out", 32'(obs_byte), 32'(exp_q[0]));
            if (obs_invalid) inv_seen++;
            pend_inv = 1'b0;
            if (exp_valid && byte_ready) begin
                got_bytes.push_back(obs_byte);
                void'(exp_q.pop_front());
            end
            if (cp_valid && exp_ready) begin
                modelAccept(cp_list[0], bad);
                pend_inv = bad;
                void'(cp_list.pop_front());
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        cp_valid = 1'b0;
        used = cyc;
        if (expect_drain) checkOutput("drain", 32'(cp_list.size() + exp_q.size()), 32'd0);
    endtask

    task automatic runDirected(input string tag, input int ready_pct,
                               input logic [31:0] exp_word, input int exp_n);
        int          used;
        logic [31:0] w;
        got_bytes.delete();
        applyStimulus(2000, ready_pct, 100, 1'b1, used);
        w = 32'd0;
        foreach (got_bytes[i]) w = (w << 8) | 32'(got_bytes[i]);
        checkOutput({tag, "_bytes"}, w, exp_word);
        checkOutput({tag, "_count"}, 32'(got_bytes.size()), 32'(exp_n));
    endtask

    initial begin
        int used;
        int inv0;
        logic [31:0] w;

        n_checks    = 0;
        n_fail      = 0;
        inv_seen    = 0;
        pend_inv    = 1'b0;
        bom_sent[0] = 1'b0;
        bom_sent[1] = 1'b0;
        rst         = 1'b1;
        sel         = 1'b0;
        cp_in       = 21'd0;
        cp_valid    = 1'b0;
        be          = 1'b0;
        byte_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_byte_valid", 32'(obs_valid), 32'd0);
        checkOutput("rst_busy", 32'(obs_busy), 32'd0);
        checkOutput("rst_invalid", 32'(obs_invalid), 32'd0);
        checkOutput("rst_byte_out", 32'(obs_byte), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_cp_ready", 32'(obs_ready), 32'd1);

        // First character (BOM when enabled), then a second without BOM
        pushCp(21'h000041, 1'b1);
        runDirected("first_41", 100, BOM_ON ? 32'hFEFF0041 : 32'h00000041, BOM_ON ? 4 : 2);
        pushCp(21'h000042, 1'b1);
        runDirected("second_42", 100, 32'h00000042, 2);

        // BMP big-endian and supplementary little-endian
        pushCp(21'h0000E9, 1'b1);
        runDirected("bmp_be", 100, 32'h000000E9, 2);
        pushCp(21'h01F600, 1'b0);
        runDirected("supp_le", 100, 32'h3DD800DE, 4);

        // Invalid code points replaced by U+FFFD
        inv0 = inv_seen;
        pushCp(21'h00D800, 1'b1);
        pushCp(21'h110000, 1'b1);
        runDirected("repl_invalid", 100, 32'hFFFDFFFD, 4);
        checkOutput("repl_invalid_pulses", 32'(inv_seen - inv0), 32'd2);

        // Backpressure with byte_ready toggling
        pushCp(21'h10FFFF, 1'b1);
        runDirected("backpressure", -1, 32'hDBFFDFFF, 4);

        // Throughput: BMP every 2 cycles, supplementary every 4
        for (int i = 0; i < 4; i++) pushCp(21'($urandom_range(32'hD7FF)), 1'($urandom));
        applyStimulus(100, 100, 100, 1'b1, used);
        checkOutput("bmp_rate_cycles", 32'(used), 32'd9);
        for (int i = 0; i < 3; i++) pushCp(21'($urandom_range(32'h10FFFF, 32'h10000)), 1'($urandom));
        applyStimulus(100, 100, 100, 1'b1, used);
        checkOutput("supp_rate_cycles", 32'(used), 32'd13);

        // Randomised traffic on the replacing instance
        for (int i = 0; i < 150; i++) pushCp(randCp(), 1'($urandom));
        applyStimulus(5000, 70, 60, 1'b1, used);

        // Reset in the middle of a supplementary character
        got_bytes.delete();
        pushCp(21'h01F600, 1'b0);
        applyStimulus(3, 100, 100, 1'b0, used);
        w = 32'd0;
        foreach (got_bytes[i]) w = (w << 8) | 32'(got_bytes[i]);
        checkOutput("midchar_bytes", w, 32'h00003DD8);
        rst = 1'b1;
        #1;
        checkOutput("midchar_rst_valid", 32'(obs_valid), 32'd0);
        checkOutput("midchar_rst_busy", 32'(obs_busy), 32'd0);
        exp_q.delete();
        pend_inv    = 1'b0;
        bom_sent[0] = 1'b0;
        bom_sent[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midchar_release_ready", 32'(obs_ready), 32'd1);
        pushCp(21'h000041, 1'b1);
        runDirected("after_rst", 100, BOM_ON ? 32'hFEFF0041 : 32'h00000041, BOM_ON ? 4 : 2);

        // Dropping instance: invalid code points produce only a pulse
        sel  = 1'b1;
        inv0 = inv_seen;
        pushCp(21'h00D800, 1'b1);
        pushCp(21'h110000, 1'b1);
        runDirected("drop_invalid", 100, 32'h00000000, 0);
        checkOutput("drop_invalid_pulses", 32'(inv_seen - inv0), 32'd2);
        pushCp(21'h000041, 1'b0);
        runDirected("drop_first_le", 100, BOM_ON ? 32'hFFFE4100 : 32'h00004100, BOM_ON ? 4 : 2);

        // Randomised traffic on the dropping instance
        for (int i = 0; i < 150; i++) pushCp(randCp(), 1'($urandom));
        applyStimulus(5000, 70, 60, 1'b1, used);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/utf16_stream_encoder.md
Name: utf16_stream_encoder

Overview:
- Downstream consumer of the UTF-8 decoder core.
- Accepts one decoded 21-bit code point per valid/ready handshake and serialises it as a UTF-16 byte stream (one or two 16-bit code units), in big- or little-endian order.
- Output is one byte per handshake.
- Provides the codepoint-to-UTF-16 conversion path next to the existing UTF-8 character and byte ports.

Parameters:
- REPLACE_INVALID, 1: 1 = an invalid code point is encoded as U+FFFD; 0 = it is dropped and only flagged.

Ports:
- clk  input  1  — system clock, all state on rising edge.
- rst  input  1  — asynchronous active-high reset.
- cp_in  input  21  — code point from the decoder.
- cp_valid  input  1  — cp_in is presented.
- cp_ready  output  1  — encoder accepts cp_in this cycle.
- be  input  1  — 1 = big-endian byte order, 0 = little-endian; sampled at accept.
- byte_out  output  8  — current UTF-16 byte.
- byte_valid  output  1  — byte_out is valid.
- byte_ready  input  1  — sink takes byte_out this cycle.
- invalid  output  1  — one-cycle pulse on accept of a surrogate or a value >0x10FFFF.
- busy  output  1  — a code point is latched and not yet fully emitted.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; byte_out=0x00; byte_valid=0; invalid=0; busy=0.
  - cp_ready=1 after release.
  - A reset mid-character abandons all remaining bytes; no partial completion.
- Accept occurs on a cycle with cp_valid & cp_ready. At accept the block latches the code units, be and the unit count; cp_in is not held afterwards.
- Classification of the accepted cp_in:
  - cp <= 0xFFFF and not 0xD800–0xDFFF: one unit, equal to cp.
  - 0x10000–0x10FFFF: two units. v = cp − 0x10000 (20 bits); hi = 0xD800 | v[19:10]; lo = 0xDC00 | v[9:0].
  - 0xD800–0xDFFF or > 0x10FFFF: invalid.
    - invalid pulses the cycle after accept.
    - REPLACE_INVALID=1: emit 0xFFFD as one unit.
    - REPLACE_INVALID=0: emit nothing; state returns to IDLE and no byte_valid is raised.
- FSM states: IDLE, U0A, U0B, U1A, U1B. "A" is the first byte of a unit on the wire, "B" the second.
  - BE: A = unit[15:8], B = unit[7:0]. LE: A = unit[7:0], B = unit[15:8].
  - IDLE -> U0A on accept (unless dropped).
  - U0A -> U0B on byte_ready.
  - U0B -> U1A on byte_ready if the character has two units, else -> IDLE.
  - U1A -> U1B -> IDLE, each step on byte_ready.
- Latency and handshake:
  - byte_out and byte_valid are registered; the first byte is valid the cycle after accept.
  - byte_out and byte_valid are held stable while byte_valid & ~byte_ready.
  - byte_valid=1 in every U* state.
- Throughput:
  - cp_ready = (state==IDLE) | (final byte & byte_ready). A back-to-back accept on the final-byte handshake loads the next character with no bubble.
  - Result: a BMP character every 2 cycles, a supplementary character every 4 cycles.
- busy = (state != IDLE).
- be changes while a character is being emitted have no effect until the next accept.
- cp_in bits are never truncated. Any value > 0x10FFFF, including 0x1FFFFF, is invalid.

Optional Feature:
- Macro UTF16_BOM_EN.
- Defined: the first accepted code point after reset is preceded by a byte-order mark, U+FEFF, as a unit in the order given by the be sampled at that accept.
  - BE emits FE FF; LE emits FF FE.
  - Uses an extra BOM_A/BOM_B state pair entered before U0A.
  - A bom_sent flag clears only on rst.
  - In REPLACE_INVALID=0, a dropped first code point does not emit the BOM and does not set bom_sent.
- Undefined: no BOM logic, flag or states; the byte stream starts with the first code unit.

Decomposition:
- Package utf_pkg holds:
  - Constants CP_MAX=21'h10FFFF, CP_REPL=16'hFFFD, CP_BOM=16'hFEFF, SURR_HI=16'hD800, SURR_LO=16'hDC00, SUPP_BASE=21'h10000.
  - The FSM state enum.
- Sub-module utf16_unit_split is combinational: cp -> {hi, lo, pair, bad}. It is reusable by a later UTF-16 decoder checker.

Test Plan:
- BMP, BE: cp=0x00E9, be=1, byte_ready=1 -> bytes 0x00, 0xE9 on consecutive cycles; cp_ready high on the 0xE9 cycle.
- Supplementary, LE: cp=0x1F600, be=0 -> bytes 0x3D, 0xD8, 0x00, 0xDE (units D83D DE00); invalid=0.
- Invalid: cp=0xD800, then cp=0x110000.
  - REPLACE_INVALID=1, BE -> each yields FF FD with an invalid pulse.
  - REPLACE_INVALID=0 -> no bytes, an invalid pulse for each, cp_ready back high the next cycle.
- Backpressure: cp=0x10FFFF, BE, byte_ready toggling 0/1 -> DB FF DF FF, each byte held stable while stalled; busy high until the last handshake.
- Reset mid-character: assert rst after the second byte of 0x1F600 -> byte_valid=0 and busy=0 immediately (async); after release, cp=0x0041 yields 00 41 only.
- UTF16_BOM_EN: after reset, cp=0x0041 BE -> FE FF 00 41; a second cp=0x0042 -> 00 42 with no BOM.
